dense_layer_sequencer: RTL and testbench
========================================

DENSE_LAYER_SEQUENCER -- requirements
Module: dense_layer_sequencer

Interface
REQ-001 SHALL have parameter IN_AW, default 10, activation address width (max 1024 inputs).
REQ-002 SHALL have parameter OUT_AW, default 7, neuron/bias/output address width (max 128 outputs).
REQ-003 SHALL have parameter W_AW, default 17, weight address width.
REQ-004 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_start  in  1  start one layer pass; sampled in IDLE only.
REQ-007 SHALL have port i_n_in  in  IN_AW+1  input vector length (0..2^IN_AW).
REQ-008 SHALL have port i_n_out  in  OUT_AW+1  neuron count (0..2^OUT_AW).
REQ-009 SHALL have port i_no_relu  in  1  1 = linear layer, 0 = ReLU.
REQ-010 SHALL have ports i_input_zp, i_filter_zp, i_output_zp  in  8 each  signed zero points.
REQ-011 SHALL have ports i_quant_mult  in  32  signed; i_quant_shift  in  8  signed.
REQ-012 SHALL have ports o_act_addr  out  IN_AW; i_act_data  in  8  (sync RAM, 1-cycle latency).
REQ-013 SHALL have ports o_wgt_addr  out  W_AW; i_wgt_data  in  8  (sync RAM, 1-cycle latency).
REQ-014 SHALL have ports o_bias_addr  out  OUT_AW; i_bias_data  in  32  (sync RAM, 1-cycle latency).
REQ-015 SHALL have ports o_mul_a, o_mul_b  out  16  registered multiplier operands; i_mul_p  in  32  combinational product.
REQ-016 SHALL have ports o_out_we  out  1; o_out_addr  out  OUT_AW; o_out_data  out  8.
REQ-017 SHALL have ports o_busy  out  1; o_done  out  1  (single-cycle pulse).

Function
REQ-018 SHALL implement FSM IDLE -> MAC -> BIAS -> QUANT -> WRITE -> (MAC for next neuron | DONE) -> IDLE.
REQ-019 IDLE: i_start=1 latches all configuration inputs, clears neuron index j and accumulator, enters MAC; i_start ignored in all other states.
REQ-020 MAC: cycle k (0..n_in-1) drives o_act_addr=k, o_wgt_addr=j*n_in+k; cycle k+1 registers o_mul_a=sext(act)-sext(input_zp), o_mul_b=sext(wgt)-sext(filter_zp); cycle k+2 adds i_mul_p to the 32-bit accumulator (wrap-around); MAC lasts n_in+2 cycles; o_bias_addr=j throughout.
REQ-021 BIAS: acc += i_bias_data (1 cycle). QUANT: 1 cycle, computes result per REQ-022. WRITE: o_out_we=1, o_out_addr=j, o_out_data=result for exactly 1 cycle.
REQ-022 Requant: r=(no_relu||!acc[31])?acc:0; ts=31-quant_shift; p=64-bit signed r*quant_mult + (ts>0 ? 1<<(ts-1) : 0); q=p>>>ts; result=(q+sext(output_zp))[7:0].
REQ-023 Per-neuron latency SHALL be n_in+5 cycles; o_done SHALL pulse in DONE, exactly n_out*(n_in+5)+1 cycles after the start cycle.
REQ-024 n_in=0: MAC lasts 2 cycles with no accumulation; output = requant(bias).
REQ-025 n_out=0: IDLE -> DONE directly; no o_out_we; o_done one cycle after start.
REQ-026 o_busy=1 in every state except IDLE.

Reset
REQ-027 Assertion of i_rst_n=0 at any time, including mid-layer, SHALL force IDLE, acc=0, j=0, and all outputs (addresses, operands, o_out_*, o_busy, o_done) to 0; no partial write completes.

Configuration
REQ-028 With SATURATE_OUTPUT_EN defined, q+output_zp SHALL clamp to [-128,127] before driving o_out_data.
REQ-029 Without SATURATE_OUTPUT_EN, o_out_data SHALL be the plain low 8 bits (bit-exact with the golden software model).

Structure
REQ-030 Package dense_seq_pkg SHALL hold the state enum, default widths, and ACC_W=32, PROD_W=64 constants.
REQ-031 Requantization (REQ-022, REQ-028/029) SHALL be a combinational sub-module requant_unit, instantiated once.

Verification
REQ-032 n_in=2, n_out=1, act={3,4}, wgt={5,6}, zps 0, bias=0, mult=2^30, shift=0 -> acc=39, out=20 at addr 0, o_done 8 cycles after start.
REQ-033 ReLU vs linear: acc=-100, output_zp=5, mult=2^30, shift=0 -> ReLU out=5; linear out=-45 (0xD3).
REQ-034 Zero points: act=10, input_zp=-128, wgt=1, filter_zp=1 -> o_mul_a=138, o_mul_b=0, acc=bias.
REQ-035 n_out=0 -> o_done one cycle after start, no writes; n_in=0, bias=200, mult=2^30, shift=0 -> out=100.
REQ-036 Saturation: q=300, output_zp=0 -> 127 with SATURATE_OUTPUT_EN, 0x2C without.
REQ-037 Reset mid-MAC on neuron 3 of 10 -> all outputs 0 next edge, i_start accepted in IDLE, full rerun matches golden outputs.

Source files
------------

// File: rtl/dense_seq_pkg.sv
// dense_seq_pkg: shared state encoding, default widths and arithmetic widths for the dense layer sequencer
package dense_seq_pkg;
  typedef enum logic [2:0] {IDLE, MAC, BIAS, QUANT, WRITE, DONE} state_t;
  localparam int IN_AW_D = 10;
  localparam int OUT_AW_D = 7;
  localparam int W_AW_D = 17;
  localparam int ACC_W = 32;
  localparam int PROD_W = 64;
endpackage

// File: rtl/requant_unit.sv
// requant_unit: combinational ReLU, fixed-point rescale with rounding and output zero point
// SATURATE_OUTPUT_EN clamps the result to int8 instead of keeping the low 8 bits
module requant_unit import dense_seq_pkg::*; (
  input  logic [ACC_W-1:0] acc,
  input  logic             no_relu,
  input  logic [31:0]      quant_mult,
  input  logic [7:0]       quant_shift,
  input  logic [7:0]       output_zp,
  output logic [7:0]       result
);
  logic signed [ACC_W-1:0] r;
  logic signed [9:0] ts;
  logic signed [PROD_W-1:0] p, q;
`ifdef SATURATE_OUTPUT_EN
  logic signed [PROD_W-1:0] s;
`endif
  always_comb begin
    r = (no_relu || !acc[ACC_W-1]) ? $signed(acc) : '0;
    ts = 10'sd31 - $signed({{2{quant_shift[7]}}, quant_shift});
    p = PROD_W'(r) * PROD_W'($signed(quant_mult)) + ((ts > 10'sd0) ? (64'sd1 <<< (ts - 10'sd1)) : 64'sd0);
    // a negative total shift scales up rather than down
    q = ts[9] ? (p <<< (-ts)) : (p >>> ts);
`ifdef SATURATE_OUTPUT_EN
    s = q + PROD_W'($signed(output_zp));
    result = (s > 64'sd127) ? 8'h7f : (s < -64'sd128) ? 8'h80 : s[7:0];
`else
    result = 8'(q + PROD_W'($signed(output_zp)));
`endif
  end
endmodule

// File: rtl/dense_layer_sequencer.sv
// dense_layer_sequencer: sequences one quantized fully-connected layer over external RAMs and multiplier
// Build option SATURATE_OUTPUT_EN selects int8 saturation in requant_unit
module dense_layer_sequencer import dense_seq_pkg::*; #(
  parameter int IN_AW = IN_AW_D,
  parameter int OUT_AW = OUT_AW_D,
  parameter int W_AW = W_AW_D
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [IN_AW:0]    i_n_in,
  input  logic [OUT_AW:0]   i_n_out,
  input  logic              i_no_relu,
  input  logic [7:0]        i_input_zp,
  input  logic [7:0]        i_filter_zp,
  input  logic [7:0]        i_output_zp,
  input  logic [31:0]       i_quant_mult,
  input  logic [7:0]        i_quant_shift,
  output logic [IN_AW-1:0]  o_act_addr,
  input  logic [7:0]        i_act_data,
  output logic [W_AW-1:0]   o_wgt_addr,
  input  logic [7:0]        i_wgt_data,
  output logic [OUT_AW-1:0] o_bias_addr,
  input  logic [31:0]       i_bias_data,
  output logic [15:0]       o_mul_a,
  output logic [15:0]       o_mul_b,
  input  logic [31:0]       i_mul_p,
  output logic              o_out_we,
  output logic [OUT_AW-1:0] o_out_addr,
  output logic [7:0]        o_out_data,
  output logic              o_busy,
  output logic              o_done
);
  state_t state, nxt;
  logic [IN_AW+1:0] k, n_in_x;
  logic [IN_AW:0] n_in;
  logic [OUT_AW:0] n_out, j;
  logic [W_AW-1:0] wbase;
  logic [ACC_W-1:0] acc;
  logic [31:0] mult;
  logic [7:0] izp, fzp, ozp, shift, res, rq;
  logic no_relu, issue, v1, v2;
  assign n_in_x = (IN_AW+2)'(n_in);
  assign issue = (state == MAC) && (k < n_in_x);
  assign o_act_addr = issue ? k[IN_AW-1:0] : '0;
  assign o_wgt_addr = issue ? wbase + W_AW'(k) : '0;
  assign o_bias_addr = j[OUT_AW-1:0];
  assign o_out_we = state == WRITE;
  assign o_out_addr = o_out_we ? j[OUT_AW-1:0] : '0;
  assign o_out_data = o_out_we ? res : '0;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  requant_unit u_requant (
    .acc(acc), .no_relu(no_relu), .quant_mult(mult), .quant_shift(shift),
    .output_zp(ozp), .result(rq)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !i_start ? IDLE : (i_n_out == '0) ? DONE : MAC;
      MAC:     nxt = (k == n_in_x + (IN_AW+2)'(1)) ? BIAS : MAC;
      BIAS:    nxt = QUANT;
      QUANT:   nxt = WRITE;
      WRITE:   nxt = (j + (OUT_AW+1)'(1) == n_out) ? DONE : MAC;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      {k, n_in, n_out, j, wbase, acc, mult, izp, fzp, ozp, shift, res, no_relu, v1, v2} <= '0;
      o_mul_a <= '0;
      o_mul_b <= '0;
    end else begin
      state <= nxt;
      v1 <= issue;
      v2 <= v1;
      // operands form one cycle after the address, the product is accumulated one cycle later
      if (v1) begin
        o_mul_a <= {{8{i_act_data[7]}}, i_act_data} - {{8{izp[7]}}, izp};
        o_mul_b <= {{8{i_wgt_data[7]}}, i_wgt_data} - {{8{fzp[7]}}, fzp};
      end
      case (state)
        IDLE: if (i_start) begin
          {n_in, n_out, no_relu, izp, fzp, ozp, mult, shift} <= {i_n_in, i_n_out, i_no_relu, i_input_zp,
            i_filter_zp, i_output_zp, i_quant_mult, i_quant_shift};
          {j, acc, k, wbase} <= '0;
        end
        MAC: begin
          k <= k + 1'b1;
          if (v2) acc <= acc + i_mul_p;
        end
        BIAS:  acc <= acc + i_bias_data;
        QUANT: res <= rq;
        WRITE: begin
          j <= j + 1'b1;
          k <= '0;
          acc <= '0;
          wbase <= wbase + W_AW'(n_in);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dense_layer_sequencer.sv
// tb_dense_layer_sequencer: randomized scoreboard bench against a plain-arithmetic layer model
module tb_dense_layer_sequencer;
  logic i_clk = 0, i_rst_n = 0, i_start = 0, i_no_relu = 0;
  logic [10:0] i_n_in = 0;
  logic [7:0] i_n_out = 0;
  logic [7:0] i_input_zp = 0, i_filter_zp = 0, i_output_zp = 0, i_quant_shift = 0;
  logic [31:0] i_quant_mult = 0;
  logic [9:0] o_act_addr;
  logic [16:0] o_wgt_addr;
  logic [6:0] o_bias_addr, o_out_addr;
  logic [7:0] i_act_data, i_wgt_data, o_out_data;
  logic [31:0] i_bias_data, i_mul_p;
  logic [15:0] o_mul_a, o_mul_b;
  logic o_out_we, o_busy, o_done;

  dense_layer_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_n_in(i_n_in), .i_n_out(i_n_out),
    .i_no_relu(i_no_relu), .i_input_zp(i_input_zp), .i_filter_zp(i_filter_zp),
    .i_output_zp(i_output_zp), .i_quant_mult(i_quant_mult), .i_quant_shift(i_quant_shift),
    .o_act_addr(o_act_addr), .i_act_data(i_act_data), .o_wgt_addr(o_wgt_addr),
    .i_wgt_data(i_wgt_data), .o_bias_addr(o_bias_addr), .i_bias_data(i_bias_data),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .i_mul_p(i_mul_p), .o_out_we(o_out_we),
    .o_out_addr(o_out_addr), .o_out_data(o_out_data), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] act_mem [0:1023];
  logic [7:0] wgt_mem [0:4095];
  logic [31:0] bias_mem [0:127];
  always @(posedge i_clk) begin
    i_act_data <= act_mem[o_act_addr];
    i_wgt_data <= wgt_mem[o_wgt_addr[11:0]];
    i_bias_data <= bias_mem[o_bias_addr];
  end
  assign i_mul_p = $signed(o_mul_a) * $signed(o_mul_b);

  typedef struct {int addr; int data;} wr_t;
  wr_t sb_q[$];
  int done_q[$];
  int cnt = 0, errors = 0, checks = 0, ndone = 0;
  always @(posedge i_clk) cnt <= cnt + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic err(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, none required", nm);
  endtask

  // layer output for neuron j computed directly from the requantization formula
  function automatic logic [7:0] golden(input int j);
    int acc, ts;
    longint r, p, q, s;
    acc = int'(bias_mem[j]);
    for (int k = 0; k < int'(i_n_in); k++)
      acc += (int'($signed(act_mem[k])) - int'($signed(i_input_zp))) *
             (int'($signed(wgt_mem[j * int'(i_n_in) + k])) - int'($signed(i_filter_zp)));
    r = (i_no_relu || acc >= 0) ? longint'(acc) : 0;
    ts = 31 - int'($signed(i_quant_shift));
    p = r * longint'($signed(i_quant_mult)) + (ts > 0 ? (longint'(1) << (ts - 1)) : 0);
    q = p >>> ts;
    s = q + longint'($signed(i_output_zp));
`ifdef SATURATE_OUTPUT_EN
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
`endif
    return s[7:0];
  endfunction

  always @(negedge i_clk) begin
    wr_t e;
    if (i_rst_n) begin
      if (o_out_we) begin
        if (sb_q.size() == 0) err("unexpected_write");
        else begin
          e = sb_q.pop_front();
          chk("out_addr", o_out_addr, e.addr);
          chk("out_data", o_out_data, e.data);
        end
      end
      if (o_done) begin
        ndone++;
        if (done_q.size() == 0) err("unexpected_done");
        else chk("done_cycle", cnt, done_q.pop_front());
        chk("pending_writes_at_done", sb_q.size(), 0);
        chk("busy_in_done", o_busy, 1);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_act_addr"}, o_act_addr, 0);
    chk({tag, "_wgt_addr"}, o_wgt_addr, 0);
    chk({tag, "_bias_addr"}, o_bias_addr, 0);
    chk({tag, "_mul_a"}, o_mul_a, 0);
    chk({tag, "_mul_b"}, o_mul_b, 0);
    chk({tag, "_out_we"}, o_out_we, 0);
    chk({tag, "_out_addr"}, o_out_addr, 0);
    chk({tag, "_out_data"}, o_out_data, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  task automatic cfg(input int ni, input int no, input bit lin, input int izp, input int fzp,
                     input int ozp, input int mult, input int sh);
    i_n_in = 11'(ni); i_n_out = 8'(no); i_no_relu = lin;
    i_input_zp = 8'(izp); i_filter_zp = 8'(fzp); i_output_zp = 8'(ozp);
    i_quant_mult = mult; i_quant_shift = 8'(sh);
  endtask

  task automatic push_expected(input int exp0);
    for (int j = 0; j < int'(i_n_out); j++)
      sb_q.push_back('{j, (exp0 >= 0) ? exp0 : int'(golden(j))});
    done_q.push_back(cnt + int'(i_n_out) * (int'(i_n_in) + 5) + 1);
  endtask

  task automatic run_layer(input int exp0, input bit chk_mul, input int ea, input int eb);
    int d0;
    @(negedge i_clk);
    d0 = ndone;
    push_expected(exp0);
    i_start = 1;
    @(negedge i_clk);
    i_start = 0;
    if (chk_mul) begin
      repeat (2) @(negedge i_clk);
      chk("mul_a", longint'($signed(o_mul_a)), ea);
      chk("mul_b", longint'($signed(o_mul_b)), eb);
    end
    for (int c = 0; c < 20000 && ndone == d0; c++) @(negedge i_clk);
    if (ndone == d0) err("done_timeout");
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) act_mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) wgt_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) bias_mem[i] = $urandom;
  endtask

  initial begin
    fill_random();
    repeat (3) @(negedge i_clk);
    check_zero("reset");
    i_rst_n = 1;

    cfg(2, 1, 0, 0, 0, 0, 1 << 30, 0);
    act_mem[0] = 3; act_mem[1] = 4; wgt_mem[0] = 5; wgt_mem[1] = 6; bias_mem[0] = 0;
    run_layer(20, 0, 0, 0);

    cfg(1, 1, 0, 0, 0, 5, 1 << 30, 0);
    act_mem[0] = 8'h9c; wgt_mem[0] = 1;
    run_layer(5, 0, 0, 0);
    i_no_relu = 1;
    run_layer(8'hd3, 0, 0, 0);

    cfg(1, 1, 1, -128, 1, 0, 1 << 30, 0);
    act_mem[0] = 10; wgt_mem[0] = 1; bias_mem[0] = 77;
    run_layer(39, 1, 138, 0);

    cfg(4, 0, 0, 0, 0, 0, 1 << 30, 0);
    run_layer(0, 0, 0, 0);
    cfg(0, 1, 0, 0, 0, 0, 1 << 30, 0);
    bias_mem[0] = 200;
    run_layer(100, 0, 0, 0);

    bias_mem[0] = 600;
`ifdef SATURATE_OUTPUT_EN
    run_layer(127, 0, 0, 0);
`else
    run_layer(8'h2c, 0, 0, 0);
`endif

    for (int t = 0; t < 10; t++) begin
      fill_random();
      cfg($urandom_range(0, 12), $urandom_range(0, 5), 1'($urandom), $urandom, $urandom,
          $urandom, $urandom, $urandom_range(0, 15));
      run_layer(-1, 0, 0, 0);
    end

    fill_random();
    cfg(6, 10, 0, $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 15));
    @(negedge i_clk);
    push_expected(-1);
    i_start = 1;
    @(negedge i_clk);
    i_start = 0;
    for (int c = 0; c < 2000 && o_bias_addr != 3; c++) @(negedge i_clk);
    chk("reached_neuron3", o_bias_addr, 3);
    repeat (2) @(negedge i_clk);
    i_rst_n = 0;
    #1;
    check_zero("midreset");
    sb_q.delete();
    done_q.delete();
    @(negedge i_clk);
    i_rst_n = 1;
    run_layer(-1, 0, 0, 0);

    repeat (3) @(negedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
